// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/grant_decode.sv
// 3-to-8 one-hot decode of the owner index, forced to zero when disabled.
module grant_decode
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  // Decode the index into a one-hot vector, all zero when not enabled.
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      case (idx)
        3'd0:    onehot = 8'h01;
        3'd1:    onehot = 8'h02;
        3'd2:    onehot = 8'h04;
        3'd3:    onehot = 8'h08;
        3'd4:    onehot = 8'h10;
        3'd5:    onehot = 8'h20;
        3'd6:    onehot = 8'h40;
        3'd7:    onehot = 8'h80;
        default: onehot = 8'h00;
      endcase
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters; a grant is held until the owner
// drops its request. Optional forced release after MAX_HOLD cycles is
// enabled by defining the macro ARB_TIMEOUT_EN.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // The hold counter must be able to represent MAX_HOLD-1.
  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_cnt_w_too_small
    $error("rr_arbiter8: CNT_W too small for MAX_HOLD");
  end

  arb_state_t state;
  arb_state_t state_nxt;
  idx_t       ptr;
  idx_t       ptr_nxt;
  idx_t       idx_nxt;
  idx_t       winner;
  idx_t       cand;
  logic       found;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             timeout_r;
  logic             timeout_nxt;
`endif

  // Rotating find-first: first requester at or after ptr, wrapping mod 8.
  always_comb begin
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand   = ptr + idx_t'(k);
      winner = (req[cand] && !found) ? cand : winner;
      found  = found | req[cand];
    end
  end

  // Next-state logic: grant from IDLE, hold or release in GRANT.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
`ifdef ARB_TIMEOUT_EN
          hold_nxt  = {CNT_W{1'b0}};
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          // Voluntary release; owner moves to lowest priority.
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + 3'd1;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            // Owner overstayed: force it off and rotate past it.
            state_nxt   = IDLE;
            ptr_nxt     = gnt_idx + 3'd1;
            timeout_nxt = 1'b1;
          end else begin
            state_nxt = GRANT;
            hold_nxt  = (hold_cnt == {CNT_W{1'b1}}) ? hold_cnt
                                                    : hold_cnt + CNT_W'(1);
          end
`else
          state_nxt = GRANT;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbitration state: FSM state, priority pointer and owner index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt_idx <= 3'd0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= idx_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle forced-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      hold_cnt  <= hold_nxt;
      timeout_r <= timeout_nxt;
    end
  end

  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_valid = (state == GRANT);

  grant_decode u_grant_decode (
    .idx    (gnt_idx),
    .en     (gnt_valid),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed vector table, hand-written
// corner sequences and randomized traffic against a reference model.
// Define ARB_TIMEOUT_EN to also exercise the forced-release feature.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = none), priority start, cycles held, pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } vec_t;

  vec_t tbl [8];

  rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  // One clock of the arbitration rules applied to request vector r.
  function automatic void model_step(input logic [7:0] r);
    bit done;
    int cand;
    m_to = 1'b0;
    if (m_owner < 0) begin
      done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        cand = (m_ptr + k) % 8;
        if (!done && r[cand]) begin
          m_owner = cand;
          m_hold  = 0;
          done    = 1'b1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == TB_MAX_HOLD - 1) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end
  endfunction

  task automatic compare_model(input string tag);
    logic [7:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check({tag, ".gnt"}, gnt, exp_gnt);
    check({tag, ".valid"}, 8'(gnt_valid), 8'(m_owner >= 0));
    if (m_owner >= 0) check({tag, ".idx"}, 8'(gnt_idx), 8'(m_owner));
    check({tag, ".timeout"}, 8'(timeout), 8'(m_to));
  endtask

  // Apply r just after a falling edge, clock once, compare at the next falling edge.
  task automatic step(input logic [7:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic do_reset();
    req   = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.gnt", gnt, 8'h00);
    check("reset.idx", 8'(gnt_idx), 8'h00);
    check("reset.valid", 8'(gnt_valid), 8'h00);
    check("reset.timeout", 8'(timeout), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] r;
    int k;

    tbl[0] = '{req: 8'h24, gnt: 8'h04, idx: 3'd2, valid: 1'b1};
    tbl[1] = '{req: 8'h20, gnt: 8'h00, idx: 3'd0, valid: 1'b0};
    tbl[2] = '{req: 8'h20, gnt: 8'h20, idx: 3'd5, valid: 1'b1};
    tbl[3] = '{req: 8'h20, gnt: 8'h20, idx: 3'd5, valid: 1'b1};
    tbl[4] = '{req: 8'h81, gnt: 8'h00, idx: 3'd0, valid: 1'b0};
    tbl[5] = '{req: 8'h81, gnt: 8'h80, idx: 3'd7, valid: 1'b1};
    tbl[6] = '{req: 8'h41, gnt: 8'h00, idx: 3'd0, valid: 1'b0};
    tbl[7] = '{req: 8'h41, gnt: 8'h01, idx: 3'd0, valid: 1'b1};

    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);

    // Idle: no requests, no grant.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(8'h00, "idle");
      check("idle.gnt_zero", gnt, 8'h00);
    end

    // Directed table: basic grant, dead cycle, ptr rotation and 7->0 wrap.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].req, "tbl_model");
      check($sformatf("tbl[%0d].gnt", i), gnt, tbl[i].gnt);
      check($sformatf("tbl[%0d].valid", i), 8'(gnt_valid), 8'(tbl[i].valid));
      if (tbl[i].valid) check($sformatf("tbl[%0d].idx", i), 8'(gnt_idx), 8'(tbl[i].idx));
    end

    // All requesting: owners 0..7 then 0 again, each held 2 cycles, 1 bubble.
    do_reset();
    for (int n = 0; n < 9; n++) begin
      k = n % 8;
      step(8'hFF, "rr_grant");
      check($sformatf("rr[%0d].gnt", n), gnt, 8'(1 << k));
      step(8'hFF, "rr_hold");
      check($sformatf("rr[%0d].hold", n), gnt, 8'(1 << k));
      r = 8'hFF & ~(8'(1 << k));
      step(r, "rr_bubble");
      check($sformatf("rr[%0d].bubble", n), 8'(gnt_valid), 8'h00);
    end

    // Asynchronous reset while granted clears the grant without a clock edge.
    do_reset();
    step(8'h10, "pre_rst");
    check("pre_rst.gnt", gnt, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.gnt", gnt, 8'h00);
    check("async_rst.valid", 8'(gnt_valid), 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h10, "post_rst");
    check("post_rst.gnt", gnt, 8'h10);

`ifdef ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles, then the other requester wins.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h03, "to_hold");
      check($sformatf("to_hold[%0d].gnt", i), gnt, 8'h01);
    end
    step(8'h03, "to_pulse");
    check("to_pulse.gnt", gnt, 8'h00);
    check("to_pulse.timeout", 8'(timeout), 8'h01);
    step(8'h03, "to_next");
    check("to_next.gnt", gnt, 8'h02);
    check("to_next.timeout", 8'(timeout), 8'h00);
`else
    // Without the timeout a grant is held indefinitely.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(8'h03, "long_hold");
      check("long_hold.gnt", gnt, 8'h01);
      check("long_hold.timeout", 8'(timeout), 8'h00);
    end
`endif

    // Randomized traffic; owners tend to keep their request for a while.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r = 8'h00;
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
      step(r, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
